// File: rtl/pipelined_add_sub.sv
// Pipelined ripple-carry adder/subtractor: one CW-bit chunk per stage, carry
// registered between stages, global stall from the output handshake.
module pipelined_add_sub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int CW = WIDTH / STAGES;

    // Stage k register: full operands (upper chunks act as the skew line),
    // partial result with chunks 0..k filled in, and the chunk carry-out.
    logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, res_q;
    logic [STAGES-1:0]            c_q, sub_q, vld_pipe;
    logic                         cout_q, ovf_q;

    logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, res_in, res_nx;
    logic [STAGES-1:0]            c_in, sub_in, vld_in, c_nx;
    logic [STAGES-1:0][CW:0]      chunk;
    logic                         cout_nx, ovf_nx;
    logic                         adv;

    assign adv       = !vld_pipe[STAGES-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES-1];
    assign sum       = res_q[STAGES-1];
    assign cout      = cout_q;
    assign overflow  = ovf_q;

    always_comb begin
        // Subtract is a + ~b + ~cin; the stored b is already the effective one.
        a_in[0]   = a;
        b_in[0]   = sub ? ~b : b;
        c_in[0]   = cin ^ sub;
        sub_in[0] = sub;
        vld_in[0] = in_valid;
        res_in[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k]   = a_q[k-1];
            b_in[k]   = b_q[k-1];
            c_in[k]   = c_q[k-1];
            sub_in[k] = sub_q[k-1];
            vld_in[k] = vld_pipe[k-1];
            res_in[k] = res_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            chunk[k] = {1'b0, a_in[k][k*CW +: CW]} + {1'b0, b_in[k][k*CW +: CW]}
                     + {{CW{1'b0}}, c_in[k]};
            c_nx[k]   = chunk[k][CW];
            res_nx[k] = res_in[k];
            res_nx[k][k*CW +: CW] = chunk[k][CW-1:0];
        end
        cout_nx = c_nx[STAGES-1] ^ sub_in[STAGES-1];
        // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
        ovf_nx  = a_in[STAGES-1][WIDTH-1] ^ b_in[STAGES-1][WIDTH-1]
                ^ res_nx[STAGES-1][WIDTH-1] ^ c_nx[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            c_q      <= '0;
            sub_q    <= '0;
            vld_pipe <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (adv) begin
            a_q      <= a_in;
            b_q      <= b_in;
            res_q    <= res_nx;
            c_q      <= c_nx;
            sub_q    <= sub_in;
            vld_pipe <= vld_in;
            cout_q   <= cout_nx;
            ovf_q    <= ovf_nx;
        end
    end
endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: arithmetic reference model with an ordered
// scoreboard checked every cycle, plus directed literal vectors.
module tb_pipelined_add_sub;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, overflow;
    logic [15:0] a, b, sum;

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    res_t exp_q[$];

    pipelined_add_sub #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic ci, input logic sb);
        res_t r;
        int ux, uy, sx, sy, c, u, s;
        ux = x; uy = y; sx = $signed(x); sy = $signed(y); c = ci;
        if (!sb) begin
            u = ux + uy + c;
            s = sx + sy + c;
            r.cout = (u > 65535);
        end else begin
            u = ux - uy - c;
            s = sx - sy - c;
            r.cout = (u < 0);
        end
        r.sum = u[15:0];
        r.ovf = (s > 32767) || (s < -32768);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Scoreboard and protocol checker, sampled mid-cycle.
    logic        hold_prev = 1'b0;
    logic [17:0] held;
    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            check("in_ready", {31'b0, in_ready}, {31'b0, !out_valid || out_ready});
            if (hold_prev) begin
                check("stall_valid", {31'b0, out_valid}, 32'd1);
                check("stall_hold", {14'b0, sum, cout, overflow}, {14'b0, held});
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", {14'b0, sum, cout, overflow}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("scoreboard", {14'b0, sum, cout, overflow}, {14'b0, e});
                end
            end
            hold_prev = out_valid && !out_ready;
            held      = {sum, cout, overflow};
        end
    end

    // One isolated op with out_ready=1: literal result and 3-cycle latency.
    task automatic directed(input string name, input logic [15:0] x, input logic [15:0] y,
                            input logic ci, input logic sb, input logic [15:0] es,
                            input logic ec, input logic eo);
        int n;
        @(posedge clk); #1;
        a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_lat"}, n, 3);
        check({name, "_res"}, {14'b0, sum, cout, overflow}, {14'b0, es, ec, eo});
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic sb);
        logic acc;
        int   n;
        a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_sum", {16'b0, sum}, 32'd0);
        check("reset_flags", {30'b0, cout, overflow}, 32'd0);
        rst = 1'b0;
        #1;
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);

        directed("basic",     16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        directed("chain",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("chain_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("ovf_add",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed("ovf_sub",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1);
        directed("borrow",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0);
        directed("sub_cin",   16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0);

        // Backpressure: 8 back-to-back ops with a 3-cycle stall mid-stream.
        @(posedge clk); #1;
        fork
            for (int i = 0; i < 8; i++)
                send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                check("stall_in_ready", {31'b0, in_ready}, 32'd0);
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with 4 ops in flight and a 5th presented during reset.
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            a = 16'(16'h1111 * (i + 1)); b = 16'h0101; cin = 1'b0; sub = 1'b0;
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        a = 16'h1234; b = 16'h4321;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        check("rst_mid_valid", {31'b0, out_valid}, 32'd0);
        check("rst_mid_sum", {16'b0, sum}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("rst_no_stale", {31'b0, out_valid}, 32'd0);
        directed("after_rst", 16'h1234, 16'h0F0F, 1'b0, 1'b0, 16'h2143, 1'b0, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
